arbiter_grant_mux: RTL
======================

Name: arbiter_grant_mux

Overview:
- Downstream stage of the IWRR arbiter.
- Consumes the one-hot grant_valid vector and routes the granted requester's payload burst onto a single master stream (valid/ready/last).
- Buffers the burst through a 2-entry skid FIFO.
- Returns grant_ready to the arbiter once the burst has fully drained.

Parameters:
- P_REQUESTER_NUM, 3, number of requesters (matches arbiter); must be >= 2.
- P_DATA_W, 32, payload width per requester.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- grant_valid  input  P_REQUESTER_NUM  one-hot grant from arbiter.
- grant_ready  output  1  burst complete; arbiter may release grant.
- req_valid  input  P_REQUESTER_NUM  per-requester beat valid.
- req_data  input  P_REQUESTER_NUM*P_DATA_W  packed payloads; requester i at [i*P_DATA_W +: P_DATA_W].
- req_last  input  P_REQUESTER_NUM  per-requester last-beat flag.
- req_ready  output  P_REQUESTER_NUM  per-requester beat accept.
- m_valid  output  1  master beat valid.
- m_data  output  P_DATA_W  master payload.
- m_last  output  1  master last-beat flag.
- m_ready  input  1  master accept.

Behaviour:
- Interface fact: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE, sel_r=0, FIFO count=0. Outputs: grant_ready=0, req_ready=0, m_valid=0, m_data=0, m_last=0. Reset mid-burst flushes the FIFO; beats in flight are dropped.
- Beat handshakes:
  - Beat accepted from requester i when req_valid[i] & req_ready[i].
  - Master beat transferred when m_valid & m_ready.
  - m_valid, once asserted, holds with m_data/m_last stable until m_ready.
- FSM states IDLE, XFER, DRAIN, RELEASE.
- IDLE:
  - req_ready=0.
  - If grant_valid!=0, latch sel_r = index of lowest set bit, then go to XFER next cycle.
- XFER:
  - req_ready[sel_r] = (count != 2); all other req_ready bits are 0.
  - Accepted beat {req_last[sel_r], req_data[sel_r]} is pushed into the FIFO.
  - Acceptance of the last beat goes to DRAIN; req_ready drops in the following cycle.
- DRAIN:
  - req_ready=0.
  - When count==0, or the final pop happens this cycle with count==1 and no push, go to RELEASE.
- RELEASE:
  - grant_ready=1, held until grant_valid==0, then go to IDLE.
  - grant_ready is registered: high from the first RELEASE cycle.
- FIFO:
  - 2 entries; count in 0..2.
  - m_valid = (count!=0); m_data/m_last come from the head entry.
  - Simultaneous push and pop leaves count unchanged, giving 1 beat/cycle sustained.
  - Push is blocked at count==2.
  - Latency from req accept to m_valid is 1 cycle.
- grant_valid changing during XFER/DRAIN is ignored; sel_r stays latched until IDLE.
- grant_valid deasserting before RELEASE is also ignored; the burst completes.
- A 1-beat burst (last on the first beat) goes XFER -> DRAIN in one accept.

Optional Feature:
- Macro: ARBITER_GRANT_MUX_ONEHOT_CHK_EN.
- Defined:
  - Adds output port err (1 bit), reset 0.
  - In IDLE, if grant_valid has more than one bit set, err is set sticky (cleared only by rst), the grant is ignored, and the FSM stays in IDLE.
- Undefined: no err port; a multi-bit grant selects the lowest set index.

Decomposition:
- Package arbiter_pkg:
  - FSM state enum (IDLE/XFER/DRAIN/RELEASE, 2 bits).
  - Localparam helpers for index width (clog2 of P_REQUESTER_NUM, min 1).
  - FIFO depth constant 2.
- Sub-module arbiter_skid_fifo:
  - Parameter width P_DATA_W+1.
  - Ports push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data, clk, rst.

Test Plan:
- Basic burst: grant_valid=3'b010; requester 1 sends 3 beats 0xA0, 0xA1, 0xA2 (last on 0xA2); m_ready=1 -> m_data emits A0, A1, A2 on consecutive cycles with m_last on A2. grant_ready asserts 1 cycle after A2 leaves and holds until grant_valid=0.
- Backpressure: same burst with m_ready=0 for 5 cycles -> req_ready[1] drops after 2 accepts, m_data holds 0xA0 stable, no beat lost or duplicated after m_ready=1.
- Isolation: grant_valid=3'b001; req_valid=3'b111 with distinct data -> only req_ready[0] toggles; m_data carries only requester 0 payloads.
- Single-beat burst: req_last[2]=1 on first beat 0x55 -> one m beat 0x55 with m_last=1, then grant_ready.
- Reset mid-burst: assert rst after 1 of 4 beats is accepted -> next cycle m_valid=0, grant_ready=0, all req_ready=0; a new grant 3'b100 after rst deassertion is served normally.
- Option on: grant_valid=3'b011 in IDLE -> err=1 sticky, FSM stays IDLE, req_ready=0. Option off: same stimulus selects requester 0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and sizing helpers for the arbiter grant-mux stage.
// Holds the FSM state type, the skid FIFO geometry and the index-width helper.
package arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XFER    = 2'd1,
      DRAIN   = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // A single requester still needs a 1-bit select register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbiter_skid_fifo.sv
// Small skid FIFO between the selected requester and the master stream.
// Head entry is presented combinationally; occupancy is exported for the drain logic.
module arbiter_skid_fifo
   import arbiter_pkg::*;
#(
   parameter int P_WIDTH = 33
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [P_WIDTH-1:0]    push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [P_WIDTH-1:0]    pop_data,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [P_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [P_WIDTH-1:0]    mem_d [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_CNT_W-1:0] count_q, count_d;
   logic                  push;
   logic                  pop;

   function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
      return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
   endfunction

   // Full blocks the push even when a pop happens in the same cycle.
   assign push_ready = (count_q != FIFO_CNT_W'(FIFO_DEPTH));
   assign pop_valid  = (count_q != '0);
   assign pop_data   = mem_q[rd_ptr_q];
   assign count      = count_q;
   assign push       = push_valid & push_ready;
   assign pop        = pop_valid & pop_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + FIFO_CNT_W'(1);
         2'b01:   count_d = count_q - FIFO_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/arbiter_grant_mux.sv
// Routes the granted requester's burst onto one master stream and hands the grant back when drained.
// Optional ARBITER_GRANT_MUX_ONEHOT_CHK_EN adds a sticky err output for multi-bit grants seen in IDLE.
module arbiter_grant_mux
   import arbiter_pkg::*;
#(
   parameter int P_REQUESTER_NUM = 3,
   parameter int P_DATA_W        = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [P_REQUESTER_NUM-1:0]          grant_valid,
   output logic                                grant_ready,
   input  logic [P_REQUESTER_NUM-1:0]          req_valid,
   input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] req_data,
   input  logic [P_REQUESTER_NUM-1:0]          req_last,
   output logic [P_REQUESTER_NUM-1:0]          req_ready,
   output logic                                m_valid,
   output logic [P_DATA_W-1:0]                 m_data,
   output logic                                m_last,
   input  logic                                m_ready
`ifdef ARBITER_GRANT_MUX_ONEHOT_CHK_EN
   ,
   output logic                                err
`endif
);

   localparam int IDX_W   = idx_width(P_REQUESTER_NUM);
   localparam int ENTRY_W = P_DATA_W + 1;

   arb_state_e                 state_q, state_d;
   logic [IDX_W-1:0]           sel_q, sel_d;
   logic                       grant_ready_q, grant_ready_d;
   logic [IDX_W-1:0]           grant_low_idx;
   logic                       grant_any;

   logic [P_DATA_W-1:0]        lane_data [P_REQUESTER_NUM];
   logic [P_REQUESTER_NUM-1:0] sel_oh;
   logic                       sel_valid;
   logic                       sel_last;
   logic [P_DATA_W-1:0]        sel_data;

   logic                       xfer_active;
   logic                       push_valid;
   logic                       push_ready;
   logic [ENTRY_W-1:0]         push_data;
   logic                       pop_valid;
   logic [ENTRY_W-1:0]         pop_data;
   logic [FIFO_CNT_W-1:0]      fifo_count;
   logic                       beat_accept;
   logic                       beat_pop;

`ifdef ARBITER_GRANT_MUX_ONEHOT_CHK_EN
   logic                       err_q, err_d;
   logic                       grant_multi;

   assign grant_multi = ($countones(grant_valid) > 1);
   assign err         = err_q;
`endif

   // Per-lane unpacking and select decode; the data path is an AND-OR mux on sel_oh.
   for (genvar gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*P_DATA_W +: P_DATA_W];
      assign sel_oh[gi]    = (sel_q == IDX_W'(gi));
      assign req_ready[gi] = xfer_active & push_ready & sel_oh[gi];
   end

   assign sel_valid = |(req_valid & sel_oh);
   assign sel_last  = |(req_last & sel_oh);

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         if (sel_oh[i]) begin
            sel_data = sel_data | lane_data[i];
         end
      end
   end

   assign grant_any = (grant_valid != '0);

   always_comb begin
      grant_low_idx = '0;
      for (int i = P_REQUESTER_NUM - 1; i >= 0; i--) begin
         if (grant_valid[i]) begin
            grant_low_idx = IDX_W'(i);
         end
      end
   end

   assign xfer_active = (state_q == XFER);
   assign push_valid  = xfer_active & sel_valid;
   assign push_data   = {sel_last, sel_data};
   assign beat_accept = push_valid & push_ready;
   assign beat_pop    = pop_valid & m_ready;

   arbiter_skid_fifo #(
      .P_WIDTH (ENTRY_W)
   ) u_skid_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_data),
      .pop_valid  (pop_valid),
      .pop_ready  (m_ready),
      .pop_data   (pop_data),
      .count      (fifo_count)
   );

   assign m_valid     = pop_valid;
   assign m_data      = pop_data[P_DATA_W-1:0];
   assign m_last      = pop_data[P_DATA_W];
   assign grant_ready = grant_ready_q;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
`ifdef ARBITER_GRANT_MUX_ONEHOT_CHK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_any) begin
`ifdef ARBITER_GRANT_MUX_ONEHOT_CHK_EN
               if (grant_multi) begin
                  err_d = 1'b1;
               end else begin
                  sel_d   = grant_low_idx;
                  state_d = XFER;
               end
`else
               sel_d   = grant_low_idx;
               state_d = XFER;
`endif
            end
         end
         XFER: begin
            if (beat_accept && sel_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Nothing is pushed in DRAIN, so the last pop empties the FIFO this cycle.
            if ((fifo_count == '0) ||
                ((fifo_count == FIFO_CNT_W'(1)) && beat_pop && !beat_accept)) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!grant_any) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      grant_ready_d = (state_d == RELEASE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         grant_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         grant_ready_q <= grant_ready_d;
      end
   end

`ifdef ARBITER_GRANT_MUX_ONEHOT_CHK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

endmodule
